// File: rtl/ifu_fetch.sv
// ifu_fetch: multicycle instruction fetch unit. It keeps exactly one instruction
// in flight: request, wait for the response, hand the word to decode, then wait
// for writeback to supply the next pc.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        ifu_valid,
  input  logic        idu_ready,
  output logic [31:0] real_ins,
  output logic [31:0] pc,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  output logic        fetch_fault
);

  localparam int unsigned XLEN  = 32;
  // Counter only has to reach TIMEOUT-1; keep at least one bit.
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_VALID   = 3'd3,
    S_WAIT_PC = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ins_q, ins_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; pc and instruction only load in their owning states.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response at the terminal count takes priority over the timeout.
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = S_FAULT;
          end else begin
            ins_d   = imem_rsp_data;
            state_d = S_VALID;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_TERM)) begin
          state_d = S_FAULT;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_VALID: begin
        if (idu_ready) state_d = S_WAIT_PC;
      end
      S_WAIT_PC: begin
        if (next_pc_valid) begin
          pc_d    = next_pc;
          state_d = (next_pc[1:0] == 2'b00) ? S_REQ : S_FAULT;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Outputs decoded from the registered state and datapath.
  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    ifu_valid      = (state_q == S_VALID);
    fetch_fault    = (state_q == S_FAULT);
    imem_addr      = pc_q;
    pc             = pc_q;
    real_ins       = ins_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch with a short fetch timeout.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        ifu_valid;
  logic        idu_ready;
  logic [31:0] real_ins;
  logic [31:0] pc;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic        fetch_fault;

  int vectors    = 0;
  int miscompares = 0;

  ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .ifu_valid      (ifu_valid),
    .idu_ready      (idu_ready),
    .real_ins       (real_ins),
    .pc             (pc),
    .next_pc_valid  (next_pc_valid),
    .next_pc        (next_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control outputs packed as {imem_req_valid, ifu_valid, fetch_fault}.
  task automatic ctl(input string tag, input logic rv, input logic iv, input logic ff);
    chk(tag, {29'd0, imem_req_valid, ifu_valid, fetch_fault}, {29'd0, rv, iv, ff});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    imem_rsp_err = 1'b0; idu_ready = 1'b0; next_pc_valid = 1'b0; next_pc = '0;
    tick(); tick();
    ctl("rst_ctl", 0, 0, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ins", real_ins, 32'h0);

    // Basic fetch with a one-cycle memory
    rst = 1'b0; imem_req_ready = 1'b1;
    tick();
    ctl("t1_req", 1, 0, 0);
    chk("t1_addr", imem_addr, RST_PC);
    tick();
    ctl("t1_wait", 0, 0, 0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0413;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    ctl("t1_valid", 0, 1, 0);
    chk("t1_ins", real_ins, 32'h0000_0413);
    chk("t1_pc", pc, RST_PC);

    // Decode stalls; stray response and next_pc must be ignored
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = (i == 1); imem_rsp_data = 32'hDEAD_BEEF;
      next_pc_valid  = (i == 2); next_pc = 32'h1234_5678;
      tick();
      ctl("t2_hold", 0, 1, 0);
      chk("t2_ins", real_ins, 32'h0000_0413);
      chk("t2_pc", pc, RST_PC);
    end
    imem_rsp_valid = 1'b0; next_pc_valid = 1'b0;
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    ctl("t2_acc", 0, 0, 0);

    // Request held while memory not ready
    tick();
    ctl("t3_idle", 0, 0, 0);
    chk("t3_idle_pc", pc, RST_PC);
    imem_req_ready = 1'b0; next_pc_valid = 1'b1; next_pc = 32'h8000_0010;
    tick();
    next_pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem_req_ready = 1'b1;
      ctl("t3_hold", 1, 0, 0);
      chk("t3_addr", imem_addr, 32'h8000_0010);
      tick();
    end
    ctl("t3_wait", 0, 0, 0);

    // Response at the timeout terminal count wins
    for (int i = 0; i < 7; i++) begin
      tick();
      ctl("bnd_wait", 0, 0, 0);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    ctl("bnd_rsp", 0, 1, 0);
    chk("bnd_ins", real_ins, 32'h0000_0013);
    chk("bnd_pc", pc, 32'h8000_0010);
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0; next_pc_valid = 1'b1; next_pc = 32'h8000_0020;
    tick();
    next_pc_valid = 1'b0;
    ctl("t4_req", 1, 0, 0);
    chk("t4_addr", imem_addr, 32'h8000_0020);
    tick();

    // Timeout: fault exactly 8 cycles after acceptance
    for (int i = 1; i <= 8; i++) begin
      tick();
      ctl("t4_to", 0, 0, (i == 8));
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFE_0001;
    tick();
    imem_rsp_valid = 1'b0;
    ctl("t4_late", 0, 0, 1);
    chk("t4_ins", real_ins, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      tick();
      ctl("t4_sticky", 0, 0, 1);
    end

    // Misaligned next_pc faults without a request
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ctl("t5_boot", 0, 0, 0);
    chk("t5_boot_pc", pc, RST_PC);
    chk("t5_boot_ins", real_ins, 32'h0);
    tick(); tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0093;
    tick();
    imem_rsp_valid = 1'b0;
    ctl("t5_valid", 0, 1, 0);
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0; next_pc_valid = 1'b1; next_pc = 32'h8000_0012;
    tick();
    next_pc_valid = 1'b0;
    ctl("t5_misal", 0, 0, 1);
    chk("t5_misal_pc", pc, 32'h8000_0012);
    tick(); tick();
    ctl("t5_noreq", 0, 0, 1);

    // Bus error response faults without presenting to decode
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'h0000_0073;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    ctl("t5_err", 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      ctl("t5_err_hold", 0, 0, 1);
    end

    // Reset mid-request; stale response in boot is dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    ctl("t6_wait", 0, 0, 0);
    rst = 1'b1;
    tick();
    ctl("t6_boot", 0, 0, 0);
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    ctl("t6_req", 1, 0, 0);
    chk("t6_addr", imem_addr, RST_PC);
    chk("t6_ins", real_ins, 32'h0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0517;
    tick();
    imem_rsp_valid = 1'b0;
    ctl("t6_valid", 0, 1, 0);
    chk("t6_fetch", real_ins, 32'h0000_0517);
    chk("t6_pc", pc, RST_PC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
